// File: rtl/rv_regfile_ctrl_pkg.sv
// rtl/rv_regfile_ctrl_pkg.sv - shared widths and FSM state encodings for the regfile sequencer
package rv_regfile_ctrl_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    localparam logic [2:0] ST_CLEAR   = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_WRITE   = 3'd5;
    localparam logic [2:0] ST_ACK     = 3'd6;
    localparam logic [2:0] ST_RESTORE = 3'd7;

    typedef enum logic [2:0] {
        S_CLEAR   = ST_CLEAR,
        S_IDLE    = ST_IDLE,
        S_DRAIN   = ST_DRAIN,
        S_RD_ADDR = ST_RD_ADDR,
        S_RD_DATA = ST_RD_DATA,
        S_WRITE   = ST_WRITE,
        S_ACK     = ST_ACK,
        S_RESTORE = ST_RESTORE
    } state_t;

endpackage

// File: rtl/rv_regfile_ctrl.sv
// rtl/rv_regfile_ctrl.sv - register-file port arbiter between pipeline and debug, with reset-time clear
module rv_regfile_ctrl
    import rv_regfile_ctrl_pkg::*;
#(
    parameter bit                   g_clear_on_reset = 1'b1,
    parameter logic [RF_DATA_W-1:0] g_clear_value    = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RF_ADDR_W-1:0] p_rs1_i,
    input  logic [RF_ADDR_W-1:0] p_rs2_i,
    input  logic                 p_stall_i,
    input  logic [RF_ADDR_W-1:0] p_rd_i,
    input  logic [RF_DATA_W-1:0] p_rd_value_i,
    input  logic                 p_rd_store_i,
    output logic [RF_ADDR_W-1:0] rf_rs1_o,
    output logic [RF_ADDR_W-1:0] rf_rs2_o,
    output logic                 rf_stall_o,
    output logic [RF_ADDR_W-1:0] rf_rd_o,
    output logic [RF_DATA_W-1:0] rf_rd_value_o,
    output logic                 rf_rd_store_o,
    input  logic [RF_DATA_W-1:0] rf_rs1_value_i,
    output logic                 pipe_stall_o,
    output logic                 busy_o,
    input  logic                 dbg_req_i,
    input  logic                 dbg_we_i,
    input  logic [RF_ADDR_W-1:0] dbg_addr_i,
    input  logic [RF_DATA_W-1:0] dbg_wdata_i,
    output logic                 dbg_ack_o,
    output logic [RF_DATA_W-1:0] dbg_rdata_o
);

    state_t               state;
    logic [RF_ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= g_clear_on_reset ? S_CLEAR : S_IDLE;
            clr_cnt     <= RF_ADDR_W'(1);
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            dbg_ack_o <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == RF_ADDR_W'(RF_NUM_REGS - 1)) begin
                        state <= S_RESTORE;
                    end
                end
                S_IDLE: begin
                    if (dbg_req_i && !dbg_ack_o) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // an in-flight writeback must land before debug takes the ports
                    if (!p_rd_store_i) begin
                        state <= dbg_we_i ? S_WRITE : S_RD_ADDR;
                    end
                end
                S_RD_ADDR: state <= S_RD_DATA;
                S_RD_DATA: begin
                    dbg_rdata_o <= (dbg_addr_i == '0) ? '0 : rf_rs1_value_i;
                    dbg_ack_o   <= 1'b1;
                    state       <= S_RESTORE;
                end
                S_WRITE: begin
                    dbg_ack_o <= 1'b1;
                    state     <= S_ACK;
                end
                S_ACK:     state <= S_RESTORE;
                S_RESTORE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_rs1_o      = p_rs1_i;
        rf_rs2_o      = p_rs2_i;
        rf_stall_o    = p_stall_i;
        rf_rd_o       = p_rd_i;
        rf_rd_value_o = p_rd_value_i;
        rf_rd_store_o = p_rd_store_i;
        pipe_stall_o  = 1'b1;
        busy_o        = 1'b0;
        case (state)
            S_CLEAR: begin
                rf_rs1_o      = '0;
                rf_rs2_o      = '0;
                rf_stall_o    = 1'b1;
                rf_rd_o       = clr_cnt;
                rf_rd_value_o = g_clear_value;
                rf_rd_store_o = 1'b1;
                busy_o        = 1'b1;
            end
            S_IDLE: pipe_stall_o = 1'b0;
            S_RD_ADDR: begin
                rf_rs1_o   = dbg_addr_i;
                rf_stall_o = 1'b0;
            end
            S_RD_DATA: rf_stall_o = 1'b1;
            S_WRITE: begin
                rf_stall_o    = 1'b1;
                rf_rd_o       = dbg_addr_i;
                rf_rd_value_o = dbg_wdata_i;
                rf_rd_store_o = (dbg_addr_i != '0);
            end
            S_ACK: rf_stall_o = 1'b1;
            // forced re-read reloads the file's output registers with the pipeline's operands
            S_RESTORE: rf_stall_o = 1'b0;
            default: ;
        endcase
    end

    a_wb_only_when_owned: assert property (@(posedge clk_i) disable iff (rst_i)
        p_rd_store_i |-> (state == S_IDLE || state == S_DRAIN));

endmodule

// File: tb/tb_rv_regfile_ctrl.sv
// tb/tb_rv_regfile_ctrl.sv - scoreboard bench for rv_regfile_ctrl with a behavioural register file
module tb_rv_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  p_rs1, p_rs2, p_rd;
    logic        p_stall, p_rd_store;
    logic [31:0] p_rd_value;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic        rf_stall, rf_rd_store;
    logic [31:0] rf_rd_value, rf_q;
    logic        pipe_stall, busy;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;

    logic        preload;
    logic [31:0] mem [32];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    rv_regfile_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .p_rs1_i        (p_rs1),
        .p_rs2_i        (p_rs2),
        .p_stall_i      (p_stall),
        .p_rd_i         (p_rd),
        .p_rd_value_i   (p_rd_value),
        .p_rd_store_i   (p_rd_store),
        .rf_rs1_o       (rf_rs1),
        .rf_rs2_o       (rf_rs2),
        .rf_stall_o     (rf_stall),
        .rf_rd_o        (rf_rd),
        .rf_rd_value_o  (rf_rd_value),
        .rf_rd_store_o  (rf_rd_store),
        .rf_rs1_value_i (rf_q),
        .pipe_stall_o   (pipe_stall),
        .busy_o         (busy),
        .dbg_req_i      (dbg_req),
        .dbg_we_i       (dbg_we),
        .dbg_addr_i     (dbg_addr),
        .dbg_wdata_i    (dbg_wdata),
        .dbg_ack_o      (dbg_ack),
        .dbg_rdata_o    (dbg_rdata)
    );

    // x0 is deliberately writable and not zero-forced here, so stray strobes and missing zeroing show up
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (rf_rd_store) begin
            mem[rf_rd] <= rf_rd_value;
        end
        if (!rf_stall) begin
            rf_q <= (rf_rd_store && rf_rd == rf_rs1 && rf_rd != 5'd0) ? rf_rd_value : mem[rf_rs1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_op(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rexp,
                          input int wb_cycles, input int exp_lat);
        int          n;
        logic        seen;
        logic [31:0] e;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        if (!we) exp_q.push_back(rexp);
        if (wb_cycles > 0) p_rd_store = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (n >= wb_cycles) p_rd_store = 1'b0;
            if (dbg_ack) seen = 1'b1;
        end
        chk({tag, "_ack"}, {31'd0, seen}, 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_stall_at_ack"}, {31'd0, pipe_stall}, 32'd1);
        if (!we && seen) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, dbg_rdata, e);
        end
        dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_idle_unstalled"}, {31'd0, pipe_stall}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nb, ok, nz, m;
        logic        seen;
        logic [31:0] e;
        rst = 1'b1; preload = 1'b1;
        p_rs1 = 5'd0; p_rs2 = 5'd0; p_rd = 5'd0; p_stall = 1'b1;
        p_rd_value = 32'd0; p_rd_store = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd1);
        chk("rst_clear_addr", {27'd0, rf_rd}, 32'd1);

        rst = 1'b0;
        nb = 0; ok = 0;
        while (busy && nb < 100) begin
            if (rf_rd_store && rf_rd == 5'(nb + 1) && rf_rd_value == 32'd0) ok++;
            nb++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", 32'(nb), 32'd31);
        chk("clear_write_seq", 32'(ok), 32'd31);
        chk("restore_pipe_stall", {31'd0, pipe_stall}, 32'd1);
        chk("restore_forced_read", {31'd0, rf_stall}, 32'd0);
        @(negedge clk);
        chk("idle_after_clear", {31'd0, pipe_stall}, 32'd0);
        nz = 0;
        for (int i = 1; i < 32; i++) if (mem[i] != 32'd0) nz++;
        chk("clear_nonzero_regs", 32'(nz), 32'd0);
        chk("clear_x0_untouched", mem[0], 32'hFFFF_FFFF);

        dbg_op("rd_x5", 1'b0, 5'd5, 32'd0, 32'd0, 0, 4);
        dbg_op("rd_x31", 1'b0, 5'd31, 32'd0, 32'd0, 0, 4);

        dbg_op("wr_x7", 1'b1, 5'd7, 32'hDEAD_BEEF, 32'd0, 0, 3);
        p_rs1 = 5'd7; p_stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("pipe_rd_x7", rf_q, 32'hDEAD_BEEF);
        p_stall = 1'b1;

        p_rd = 5'd3; p_rd_value = 32'h1234;
        dbg_op("rd_x7_drain", 1'b0, 5'd7, 32'd0, 32'hDEAD_BEEF, 2, 5);
        chk("drain_wb_x3", mem[3], 32'h1234);

        dbg_op("wr_x0", 1'b1, 5'd0, 32'h55, 32'd0, 0, 3);
        chk("wr_x0_no_strobe", mem[0], 32'hFFFF_FFFF);
        dbg_op("rd_x0", 1'b0, 5'd0, 32'd0, 32'd0, 0, 4);

        dbg_op("wr_x9", 1'b1, 5'd9, 32'hA5A5, 32'd0, 0, 3);
        p_rs1 = 5'd9;
        dbg_op("rd_x7_restore", 1'b0, 5'd7, 32'd0, 32'hDEAD_BEEF, 0, 4);
        chk("restore_reprimes_rs1", rf_q, 32'hA5A5);

        dbg_op("wr_x5", 1'b1, 5'd5, 32'h77, 32'd0, 0, 3);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        exp_q.push_back(32'd0);
        repeat (3) @(negedge clk);
        chk("abort_pre_ack", {31'd0, dbg_ack}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_ack", {31'd0, dbg_ack}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        m = 0; seen = 1'b0;
        while (!seen && m < 100) begin
            if (dbg_ack) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                m++;
            end
        end
        chk("abort_ack_seen", {31'd0, seen}, 32'd1);
        chk("abort_ack_lat", 32'(m), 32'd36);
        if (seen) begin
            e = exp_q.pop_front();
            chk("abort_rdata_cleared", dbg_rdata, e);
        end
        dbg_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
